raspi_link_mux: RTL

Multi-endpoint successor to the single-purpose Raspberry Pi parallel link in c3demo. It synchronises the Pi's 9-bit bus, DIR and strobe into `clk`, and decodes control words to select one of NUM_EP endpoints. Each endpoint gets its own RX FIFO (Pi→FPGA) and TX FIFO (FPGA→Pi). It sits between the top-level RASPI_* pins (tristate handled at top) and on-chip clients: link test, firmware loader, debug console.

---
 rtl/raspi_link_pkg.sv | 19 +
 rtl/raspi_link_mux_if.sv | 24 ++
 rtl/link_fifo.sv | 55 +++++
 rtl/raspi_link_mux.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/raspi_link_pkg.sv
// Shared constants and helpers for the Raspberry Pi multi-endpoint link.
package raspi_link_pkg;

  localparam logic [8:0] CMD_IDLE     = 9'h1FF;
  localparam logic [8:0] CMD_FLUSH    = 9'h1FE;
  localparam logic [8:0] CMD_SEL_BASE = 9'h100;
  localparam logic [8:0] EMPTY_WORD   = 9'h1FF;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/raspi_link_mux_if.sv
// Client-side endpoint bundle: per-endpoint RX/TX streams plus status flags.
interface raspi_link_mux_if #(
  parameter int NUM_EP = 4,
  parameter int DW     = 8
);
  logic [NUM_EP*DW-1:0] ep_rx_data;
  logic [NUM_EP-1:0]    ep_rx_valid;
  logic [NUM_EP-1:0]    ep_rx_ready;
  logic [NUM_EP*DW-1:0] ep_tx_data;
  logic [NUM_EP-1:0]    ep_tx_valid;
  logic [NUM_EP-1:0]    ep_tx_ready;
  logic [NUM_EP-1:0]    ep_active;
  logic [NUM_EP-1:0]    ep_overflow;

  modport master (
    output ep_rx_data, ep_rx_valid, ep_tx_ready, ep_active, ep_overflow,
    input  ep_rx_ready, ep_tx_data, ep_tx_valid
  );

  modport slave (
    input  ep_rx_data, ep_rx_valid, ep_tx_ready, ep_active, ep_overflow,
    output ep_rx_ready, ep_tx_data, ep_tx_valid
  );
endinterface

// File: rtl/link_fifo.sv
// First-word-fall-through FIFO with synchronous flush; the head reads as zero when empty.
module link_fifo
  import raspi_link_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          ready_o
);
  localparam int AW = clog2(DEPTH);

  logic [AW:0]   wr_q, rd_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          empty, full, pop_en, push_en;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // A pop on an empty FIFO is ignored, so a same-cycle push falls through next cycle.
  assign pop_en  = pop_i && !empty;
  assign push_en = push_i && (!full || pop_en);

  assign valid_o = !empty;
  assign ready_o = !full;
  assign data_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(push_en);
      rd_q <= rd_q + (AW+1)'(pop_en);
    end
  end

  // NOTE: storage is deliberately not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_en && !flush_i) begin
      mem_q[wr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/raspi_link_mux.sv
// Raspberry Pi parallel link: strobe synchroniser, command decoder and per-endpoint RX/TX FIFOs.
module raspi_link_mux
  import raspi_link_pkg::*;
#(
  parameter int NUM_EP      = 4,
  parameter int DW          = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raspi_clk,
  input  logic             raspi_dir,
  input  logic [DW:0]      raspi_dat_i,
  output logic [DW:0]      raspi_dat_o,
  output logic             raspi_dat_oe,
  raspi_link_mux_if.master ep
);
  localparam int          SEL_W      = (NUM_EP > 1) ? clog2(NUM_EP) : 1;
  localparam int          LAST       = SYNC_STAGES - 1;
  localparam logic [DW:0] IDLE_W     = (DW+1)'(CMD_IDLE);
  localparam logic [DW:0] FLUSH_W    = (DW+1)'(CMD_FLUSH);
  localparam logic [DW:0] SEL_BASE_W = (DW+1)'(CMD_SEL_BASE);
  localparam logic [DW:0] EMPTY_W    = (DW+1)'(EMPTY_WORD);

  logic [SYNC_STAGES-1:0] strb_sync_q, dir_sync_q;
  logic [DW:0]            dat_sync_q [SYNC_STAGES];
  logic                   edge_q, stb_q, wr_dir_q;
  logic [DW:0]            word_q, sel_off;

  logic                   sel_valid_q, sel_valid_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [NUM_EP-1:0]      ovf_q, ovf_d, ovf_set, ovf_clr;
  logic                   flush_cmd, rx_wr, tx_rd;

  logic [DW-1:0]          tx_head [NUM_EP];
  logic [NUM_EP-1:0]      tx_valid_v;

  // Sync flops reset to idle-high so a strobe still high at reset release is never seen as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strb_sync_q <= '1;
      dir_sync_q  <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) dat_sync_q[i] <= '0;
      edge_q      <= 1'b1;
      stb_q       <= 1'b0;
      wr_dir_q    <= 1'b1;
      word_q      <= '0;
    end else begin
      strb_sync_q[0] <= raspi_clk;
      dir_sync_q[0]  <= raspi_dir;
      dat_sync_q[0]  <= raspi_dat_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        strb_sync_q[i] <= strb_sync_q[i-1];
        dir_sync_q[i]  <= dir_sync_q[i-1];
        dat_sync_q[i]  <= dat_sync_q[i-1];
      end
      edge_q   <= strb_sync_q[LAST];
      stb_q    <= strb_sync_q[LAST] & ~edge_q;
      wr_dir_q <= dir_sync_q[LAST];
      word_q   <= dat_sync_q[LAST];
    end
  end

  assign raspi_dat_oe = !dir_sync_q[LAST];
  assign sel_off      = word_q - SEL_BASE_W;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_valid_d = sel_valid_q;
    sel_d       = sel_q;
    flush_cmd   = 1'b0;
    rx_wr       = 1'b0;
    tx_rd       = 1'b0;
    if (stb_q && wr_dir_q) begin
      if (word_q[DW]) begin
        if (word_q == IDLE_W) begin
          sel_valid_d = 1'b0;
        end else if (word_q == FLUSH_W) begin
          flush_cmd = sel_valid_q;
        end else if (sel_off < (DW+1)'(NUM_EP)) begin
          sel_valid_d = 1'b1;
          sel_d       = SEL_W'(sel_off);
        end else begin
          sel_valid_d = 1'b0;
        end
      end else begin
        rx_wr = sel_valid_q;
      end
    end else if (stb_q) begin
      tx_rd = sel_valid_q;
    end
  end

  assign ovf_d = (ovf_q | ovf_set) & ~ovf_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_valid_q <= 1'b0;
      sel_q       <= '0;
      ovf_q       <= '0;
    end else begin
      sel_valid_q <= sel_valid_d;
      sel_q       <= sel_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ep.ep_overflow = ovf_q;

  always_comb begin
    ep.ep_active = '0;
    raspi_dat_o  = EMPTY_W;
    if (sel_valid_q) begin
      ep.ep_active[sel_q] = 1'b1;
      if (tx_valid_v[sel_q]) raspi_dat_o = {1'b0, tx_head[sel_q]};
    end
  end

  for (genvar e = 0; e < NUM_EP; e++) begin : g_ep
    logic is_sel, flush, rx_push, rx_pop, rx_ready, tx_push, tx_pop, tx_ready;

    assign is_sel  = sel_valid_q && (sel_q == SEL_W'(e));
    assign flush   = flush_cmd && is_sel;
    assign rx_push = rx_wr && is_sel;
    assign rx_pop  = ep.ep_rx_valid[e] && ep.ep_rx_ready[e];
    assign tx_push = ep.ep_tx_valid[e] && tx_ready;
    assign tx_pop  = tx_rd && is_sel;

    // A Pi byte is only lost when the FIFO is full and the client is not freeing a slot.
    assign ovf_set[e] = rx_push && !rx_ready && !rx_pop;
    assign ovf_clr[e] = flush;
    assign ep.ep_tx_ready[e] = tx_ready;

    link_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
      .clk         (clk),
      .rst         (reset),
      .flush_i     (flush),
      .push_i      (rx_push),
      .push_data_i (word_q[DW-1:0]),
      .pop_i       (rx_pop),
      .data_o      (ep.ep_rx_data[e*DW +: DW]),
      .valid_o     (ep.ep_rx_valid[e]),
      .ready_o     (rx_ready)
    );

    link_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
      .clk         (clk),
      .rst         (reset),
      .flush_i     (flush),
      .push_i      (tx_push),
      .push_data_i (ep.ep_tx_data[e*DW +: DW]),
      .pop_i       (tx_pop),
      .data_o      (tx_head[e]),
      .valid_o     (tx_valid_v[e]),
      .ready_o     (tx_ready)
    );
  end

endmodule
